// File: rtl/tmr_count_enable_gen.sv
// tmr_count_enable_gen: selects the count-enable source for a timer channel
// (prescaler ticks, cascade event, or synchronised external clock edges).
`default_nettype none

module tmr_count_enable_gen #(
  parameter int PRESC_W     = 13,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] cks,
  input  logic       icks,
  input  logic       tmci,
  input  logic       casc_evt,
  output logic       count_en,
  output logic       stopped
);

  typedef enum logic [2:0] {
    CKS_STOP   = 3'b000,
    CKS_FAST   = 3'b001,
    CKS_MID    = 3'b010,
    CKS_SLOW   = 3'b011,
    CKS_CASC   = 3'b100,
    CKS_EXT_R  = 3'b101,
    CKS_EXT_F  = 3'b110,
    CKS_EXT_RF = 3'b111
  } cks_e;

  localparam logic [PRESC_W-1:0] PRESC_ONE = {{(PRESC_W-1){1'b0}}, 1'b1};

  logic [PRESC_W-1:0]     presc;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   hist;
  logic                   rise_q;
  logic                   fall_q;
  logic                   tick_2;
  logic                   tick_8;
  logic                   tick_32;
  logic                   tick_64;
  logic                   tick_1024;
  logic                   tick_8192;
  logic                   src;

  // Free-running; never cleared by mode changes so tick phase is preserved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else begin
      presc <= presc + PRESC_ONE;
    end
  end

  assign tick_2    = presc[0];
  assign tick_8    = &presc[2:0];
  assign tick_32   = &presc[4:0];
  assign tick_64   = &presc[5:0];
  assign tick_1024 = &presc[9:0];
  assign tick_8192 = &presc[12:0];

  generate
    if (SYNC_STAGES > 1) begin : g_sync_chain
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_q <= '0;
        end else begin
          sync_q <= {sync_q[SYNC_STAGES-2:0], tmci};
        end
      end
    end else begin : g_sync_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_q <= '0;
        end else begin
          sync_q <= tmci;
        end
      end
    end
  endgenerate

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Edge detection is registered so the external path has a fixed
  // sync + detect + output latency; it runs regardless of cks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      hist   <= sync_out;
      rise_q <= sync_out & ~hist;
      fall_q <= ~sync_out & hist;
    end
  end

  always_comb begin
    src = 1'b0;
    case (cks_e'(cks))
      CKS_STOP:   src = 1'b0;
      CKS_FAST:   src = icks ? tick_2    : tick_8;
      CKS_MID:    src = icks ? tick_32   : tick_64;
      CKS_SLOW:   src = icks ? tick_1024 : tick_8192;
      CKS_CASC:   src = casc_evt;
      CKS_EXT_R:  src = rise_q;
      CKS_EXT_F:  src = fall_q;
      CKS_EXT_RF: src = rise_q | fall_q;
      default:    src = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_en <= 1'b0;
    end else begin
      count_en <= src;
    end
  end

  assign stopped = (cks == 3'b000);

endmodule

`default_nettype wire

// File: tb/tb_tmr_count_enable_gen.sv
// Directed self-checking bench for tmr_count_enable_gen.
`default_nettype none

module tb_tmr_count_enable_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] cks;
  logic       icks;
  logic       tmci;
  logic       casc_evt;
  logic       count_en;
  logic       stopped;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  tmr_count_enable_gen #(
    .PRESC_W    (13),
    .SYNC_STAGES(2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cks     (cks),
    .icks    (icks),
    .tmci    (tmci),
    .casc_evt(casc_evt),
    .count_en(count_en),
    .stopped (stopped)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves rst_n released just after an edge, so the next edge is edge 1.
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    cks = 3'b001; icks = 1'b0; tmci = 1'b0; casc_evt = 1'b0;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (count_en !== 1'b0) $display("FAIL reset_count_en cyc=%0d got=%b exp=0", k, count_en);
      else pass_cnt++;
    end
    total++;
    if (stopped !== 1'b0) $display("FAIL reset_stopped_001 got=%b exp=0", stopped);
    else pass_cnt++;
    cks = 3'b000;
    #1;
    total++;
    if (stopped !== 1'b1) $display("FAIL reset_stopped_000 got=%b exp=1", stopped);
    else pass_cnt++;
  endtask

  task automatic test_div8();
    int pulses = 0;
    logic exp;
    cks = 3'b001; icks = 1'b0;
    do_reset();
    for (int k = 1; k <= 64; k++) begin
      tick();
      exp = (k % 8 == 0);
      pulses += int'(count_en === 1'b1);
      total++;
      if (count_en !== exp) $display("FAIL div8 cyc=%0d got=%b exp=%b", k, count_en, exp);
      else pass_cnt++;
    end
    total++;
    if (pulses !== 8) $display("FAIL div8_pulses got=%0d exp=8", pulses);
    else pass_cnt++;
  endtask

  task automatic test_div_switch();
    int pulses = 0;
    int bad = 0;
    logic exp;
    cks = 3'b011; icks = 1'b0;
    do_reset();
    for (int k = 1; k <= 8192; k++) begin
      tick();
      exp = (k == 8192);
      pulses += int'(count_en === 1'b1);
      if (count_en !== exp) bad++;
    end
    total++;
    if (pulses !== 1 || bad !== 0) $display("FAIL div8192 pulses=%0d bad=%0d exp pulses=1 bad=0", pulses, bad);
    else pass_cnt++;
    icks = 1'b1;
    pulses = 0; bad = 0;
    for (int k = 8193; k <= 11264; k++) begin
      tick();
      exp = (k % 1024 == 0);
      pulses += int'(count_en === 1'b1);
      if (count_en !== exp) begin
        bad++;
        if (bad < 4) $display("FAIL div1024 cyc=%0d got=%b exp=%b", k, count_en, exp);
      end
    end
    total++;
    if (pulses !== 3 || bad !== 0) $display("FAIL div1024_pulses pulses=%0d bad=%0d exp pulses=3 bad=0", pulses, bad);
    else pass_cnt++;
  endtask

  task automatic run_ext(input logic [2:0] mode, input int exp_pulses);
    logic lv [0:59];
    logic ev [0:59];
    logic prev;
    logic exp;
    int pulses = 0;
    for (int j = 0; j < 60; j++) lv[j] = (j < 50) && ((j % 10) < 5);
    for (int j = 0; j < 60; j++) begin
      prev = (j == 0) ? 1'b0 : lv[j-1];
      ev[j] = ((mode[0] && lv[j] && !prev) || (mode[1] && !lv[j] && prev));
    end
    cks = mode; tmci = 1'b0;
    do_reset();
    repeat (4) tick();
    for (int i = 0; i < 60; i++) begin
      tmci = lv[i];
      tick();
      exp = (i >= 3) ? ev[i-3] : 1'b0;
      pulses += int'(count_en === 1'b1);
      total++;
      if (count_en !== exp) $display("FAIL ext_mode%b cyc=%0d got=%b exp=%b", mode, i, count_en, exp);
      else pass_cnt++;
    end
    total++;
    if (pulses !== exp_pulses) $display("FAIL ext_pulses_mode%b got=%0d exp=%0d", mode, pulses, exp_pulses);
    else pass_cnt++;
  endtask

  task automatic test_ext();
    run_ext(3'b101, 5);
    run_ext(3'b111, 10);
  endtask

  task automatic test_casc();
    logic v [0:11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                       1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    int pulses = 0;
    cks = 3'b100; casc_evt = 1'b0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      casc_evt = v[i];
      tick();
      pulses += int'(count_en === 1'b1);
      total++;
      if (count_en !== v[i]) $display("FAIL casc cyc=%0d got=%b exp=%b", i, count_en, v[i]);
      else pass_cnt++;
    end
    casc_evt = 1'b0;
    total++;
    if (pulses !== 7) $display("FAIL casc_pulses got=%0d exp=7", pulses);
    else pass_cnt++;
  endtask

  task automatic test_tmci_high_at_release();
    logic exp;
    cks = 3'b101; tmci = 1'b1;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp = (k == 4);
      total++;
      if (count_en !== exp) $display("FAIL tmci_rel cyc=%0d got=%b exp=%b", k, count_en, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_static_switch();
    logic [2:0] modes [0:2] = '{3'b000, 3'b110, 3'b101};
    int pulses = 0;
    tmci = 1'b1;
    cks = 3'b000;
    do_reset();
    for (int m = 0; m < 3; m++) begin
      cks = modes[m];
      for (int k = 0; k < 8; k++) begin
        tick();
        pulses += int'(count_en === 1'b1);
      end
    end
    total++;
    if (pulses !== 0) $display("FAIL static_switch pulses got=%0d exp=0", pulses);
    else pass_cnt++;
    tmci = 1'b0;
  endtask

  task automatic test_stop_switch();
    logic exp_seq [1:6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    cks = 3'b001; icks = 1'b1;
    do_reset();
    for (int e = 1; e <= 6; e++) begin
      tick();
      total++;
      if (count_en !== exp_seq[e]) $display("FAIL stop_switch edge=%0d got=%b exp=%b", e, count_en, exp_seq[e]);
      else pass_cnt++;
      if (e == 2) begin
        cks = 3'b000;
        #1;
        total++;
        if (stopped !== 1'b1) $display("FAIL stop_switch_stopped got=%b exp=1", stopped);
        else pass_cnt++;
      end
      if (e == 4) cks = 3'b001;
    end
  endtask

  task automatic test_reset_mid();
    cks = 3'b001; icks = 1'b1;
    do_reset();
    tick();
    tick();
    total++;
    if (count_en !== 1'b1) $display("FAIL rmid_pre got=%b exp=1", count_en);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total++;
    if (count_en !== 1'b0) $display("FAIL rmid_async got=%b exp=0", count_en);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (count_en !== 1'b0) $display("FAIL rmid_hold cyc=%0d got=%b exp=0", k, count_en);
      else pass_cnt++;
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (count_en !== 1'b0) $display("FAIL rmid_e1 got=%b exp=0", count_en);
    else pass_cnt++;
    tick();
    total++;
    if (count_en !== 1'b1) $display("FAIL rmid_e2 got=%b exp=1", count_en);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_div8();
    test_div_switch();
    test_ext();
    test_casc();
    test_tmci_high_at_release();
    test_static_switch();
    test_stop_switch();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

`default_nettype wire
